seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Parametrised N-digit multiplexed 7-segment scan controller for the Basys 3 display path and wider boards.
- Cycles one active-low anode at a time, with per-digit enable, decimal points, blink, leading-zero suppression, PWM brightness and an anti-ghosting guard band.
- Digit data is snapshotted once per frame so a value change mid-scan never tears.
- Sits between the datapath's BCD/hex digit registers and the board pins.

Parameters:
- NUM_DIGITS, 4: digit count (2..8), any value, not just powers of 2.
- REFRESH_COUNT, 100000: clk cycles per digit slot.
- GUARD_CYCLES, 64: cycles at the start of each slot with all anodes off; must be < REFRESH_COUNT-1.
- BRIGHT_W, 4: width of the brightness control.
- BLINK_FRAMES, 250: full scan frames per blink half-period.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- digits  in  4*NUM_DIGITS  hex value per digit; digit k = bits [4k+3:4k]; digit 0 is rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
- digit_en  in  NUM_DIGITS  1 = digit may light
- blink_en  in  NUM_DIGITS  1 = digit blinks
- lzs_en  in  1  leading-zero suppression enable
- brightness  in  BRIGHT_W  0 = dark; all-ones = full on
- seg  out  7  cathodes {g..a}, active-low
- dp  out  1  decimal point cathode, active-low
- an  out  NUM_DIGITS  anodes, active-low, at most one low
- frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
Clock and reset:
- Single clock clk.
- Reset is synchronous and active-low on rst_n. While rst_n=0 at a clk edge, all state clears:
  - seg=7'h7F, dp=1, an=all ones, frame_tick=0
  - slot_cnt=0, digit_sel=0, pwm_cnt=0, frame_cnt=0, blink_phase=0, snapshot=0
- Reset asserted mid-scan takes effect on the next edge. No partial outputs are held.

Slot counter:
- slot_cnt counts 0..REFRESH_COUNT-1.
- At terminal count: slot_cnt<=0 and digit_sel advances. digit_sel wraps from NUM_DIGITS-1 to 0 explicitly (no power-of-2 reliance).

Frame wrap:
- Occurs on the cycle digit_sel goes NUM_DIGITS-1 -> 0.
- frame_tick is registered high for exactly 1 cycle.
- digits, dp_in, digit_en, blink_en and lzs_en are captured into the snapshot on the same edge. Input changes are invisible until the next frame.
- frame_cnt counts frames 0..BLINK_FRAMES-1. On wrap, blink_phase toggles.

PWM:
- pwm_cnt is a free-running BRIGHT_W-bit counter, incremented every cycle.
- pwm_on = (brightness == all ones) || (pwm_cnt < brightness).
- brightness is not snapshotted; it takes effect immediately.

Leading-zero suppression (snapshot lzs_en=1):
- Scanning from digit NUM_DIGITS-1 downward, each digit equal to 0 is blanked until the first nonzero digit.
- Digit 0 is never suppressed.
- Disabled digits do not break the zero run.

Digit lit condition:
- digit_en[k] && !(blink_en[k] && blink_phase) && !suppressed[k] && slot_cnt >= GUARD_CYCLES && pwm_on.

Outputs:
- Registered, one cycle after the internal state that produced them.
- When digit k is lit: an = ~(1<<k), seg = bcd_to_7seg(digit k), dp = ~dp_in[k].
- Otherwise: an=all ones, seg=7'h7F, dp=1.
- Never two anodes low in the same cycle, including across slot changes.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_BLANK = 7'h7F
  - AN_OFF helper function of NUM_DIGITS
  - clog2 helper for counter widths
  - the digit-slice function
- The existing bcd_to_7seg decoder is reused as the one sub-module, instantiated once on the selected snapshot digit. It must decode hex 0-F.
- Leading-zero mask generation is a combinational function inside seg7_scan_ctrl.

Test Plan:
All scenarios use NUM_DIGITS=3, REFRESH_COUNT=8, GUARD_CYCLES=2, BRIGHT_W=2, BLINK_FRAMES=2 unless stated.
1. Reset then scan: digits=12'h321, all enabled, brightness=3 -> an sequence 110,101,011, each low for cycles 2..7 of its slot. seg = decode(1), decode(2), decode(3). frame_tick once every 24 cycles.
2. Non-power-of-2 wrap: NUM_DIGITS=3 -> digit_sel never reaches 3, and an never equals 111 outside the guard band.
3. Snapshot: change digits 12'h321 -> 12'h654 mid-frame -> old values finish the frame; new values appear only after the next frame_tick.
4. LZS: digits=12'h007, lzs_en=1 -> digits 2 and 1 are dark and digit 0 shows 7. Same test with 12'h000 -> only digit 0 lit, showing 0.
5. Brightness: brightness=1 -> anode low 1 of every 4 cycles in the lit window. brightness=0 -> an all ones permanently.
6. Blink plus reset: blink_en=3'b010 -> digit 1 is dark every other 2-frame period. Pulse rst_n=0 for 1 cycle mid-slot -> next cycle an=111, seg=7F, dp=1, and the scan restarts at digit 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan path.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Counter width for values 0..v-1, never narrower than one bit.
  function automatic int clog2(input int v);
    int r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic [7:0] an_off(input int n);
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [3:0] digit_slice(input logic [31:0] d, input int k);
    return d[4*k +: 4];
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Hex nibble to active-low 7-segment cathode pattern, bit order {g,f,e,d,c,b,a}.
module bcd_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (value)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// N-digit multiplexed 7-segment scanner: per-frame snapshot, blink, leading-zero
// suppression, PWM brightness and an all-off guard band at the start of each slot.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_COUNT = 100000,
  parameter int GUARD_CYCLES  = 64,
  parameter int BRIGHT_W      = 4,
  parameter int BLINK_FRAMES  = 250
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    lzs_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int SLOT_W = clog2(REFRESH_COUNT);
  localparam int SEL_W  = clog2(NUM_DIGITS);
  localparam int FRM_W  = clog2(BLINK_FRAMES);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = NUM_DIGITS'(an_off(NUM_DIGITS));

  logic [SLOT_W-1:0]       slot_cnt;
  logic [SEL_W-1:0]        digit_sel;
  logic [BRIGHT_W-1:0]     pwm_cnt;
  logic [FRM_W-1:0]        frame_cnt;
  logic                    blink_phase;
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_en;
  logic [NUM_DIGITS-1:0]   snap_blink;
  logic                    snap_lzs;

  // Disabled digits are skipped so they never end a run of leading zeros.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(
    input logic [4*NUM_DIGITS-1:0] d,
    input logic [NUM_DIGITS-1:0]   en,
    input logic                    lzs
  );
    logic run = lzs;
    logic [NUM_DIGITS-1:0] m = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (en[k]) begin
        if (run && digit_slice(32'(d), k) == 4'd0) m[k] = 1'b1;
        else run = 1'b0;
      end
    end
    return m;
  endfunction

  logic                  slot_tc;
  logic                  frame_wrap;
  logic                  pwm_on;
  logic                  lit_p0;
  logic [NUM_DIGITS-1:0] suppressed;
  logic [3:0]            sel_digit;
  logic [6:0]            seg_p0;

  assign slot_tc    = (slot_cnt == SLOT_W'(REFRESH_COUNT - 1));
  assign frame_wrap = slot_tc && (digit_sel == SEL_W'(NUM_DIGITS - 1));
  assign pwm_on     = (brightness == {BRIGHT_W{1'b1}}) || (pwm_cnt < brightness);
  assign suppressed = lz_mask(snap_digits, snap_en, snap_lzs);
  assign sel_digit  = digit_slice(32'(snap_digits), int'(digit_sel));
  assign lit_p0     = snap_en[digit_sel] && !(snap_blink[digit_sel] && blink_phase) &&
                      !suppressed[digit_sel] && (slot_cnt >= SLOT_W'(GUARD_CYCLES)) && pwm_on;

  bcd_to_7seg u_dec (
    .value (sel_digit),
    .seg   (seg_p0)
  );

  // Stage p0 -> registered pins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt    <= '0;
      digit_sel   <= '0;
      pwm_cnt     <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_en     <= '0;
      snap_blink  <= '0;
      snap_lzs    <= 1'b0;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      an          <= AN_OFF;
      frame_tick  <= 1'b0;
    end else begin
      pwm_cnt    <= pwm_cnt + 1'b1;
      frame_tick <= frame_wrap;
      if (slot_tc) begin
        slot_cnt  <= '0;
        digit_sel <= (digit_sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : digit_sel + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      if (frame_wrap) begin
        snap_digits <= digits;
        snap_dp     <= dp_in;
        snap_en     <= digit_en;
        snap_blink  <= blink_en;
        snap_lzs    <= lzs_en;
        if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
      an  <= lit_p0 ? ~(NUM_DIGITS'(1) << digit_sel) : AN_OFF;
      seg <= lit_p0 ? seg_p0 : SEG_BLANK;
      dp  <= lit_p0 ? ~snap_dp[digit_sel] : 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with a cycle-count based reference model.
module tb_seg7_scan_ctrl;

  localparam int N  = 3;
  localparam int RC = 8;
  localparam int GC = 2;
  localparam int BW = 2;
  localparam int BF = 2;
  localparam int P  = RC * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4*N-1:0] digits = '0;
  logic [N-1:0]  dp_in = '0;
  logic [N-1:0]  digit_en = '0;
  logic [N-1:0]  blink_en = '0;
  logic          lzs_en = 1'b0;
  logic [BW-1:0] brightness = '0;
  logic [6:0]    seg;
  logic          dp;
  logic [N-1:0]  an;
  logic          frame_tick;

  seg7_scan_ctrl #(
    .NUM_DIGITS    (N),
    .REFRESH_COUNT (RC),
    .GUARD_CYCLES  (GC),
    .BRIGHT_W      (BW),
    .BLINK_FRAMES  (BF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits     (digits),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .blink_en   (blink_en),
    .lzs_en     (lzs_en),
    .brightness (brightness),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         dp;
    logic         tick;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_no = 0;

  // Lit segments for hex 0..F, active-high, bit order {g..a}.
  logic [6:0] hi_pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Expected pins after the edge that follows k scan cycles since reset.
  function automatic exp_t model_out(input int k, input logic [4*N-1:0] dg, input logic [N-1:0] dpm,
                                     input logic [N-1:0] en, input logic [N-1:0] bl,
                                     input logic lzs, input logic [BW-1:0] br);
    exp_t r;
    int slot = k % RC;
    int d = (k / RC) % N;
    int pwm = k % (1 << BW);
    int phase = ((k / P) / BF) % 2;
    int val = int'(dg >> (4 * d)) & 15;
    bit supp = 1'b0;
    bit lit;
    if (lzs && d > 0 && val == 0) begin
      supp = 1'b1;
      for (int j = d + 1; j < N; j++)
        if (en[j] && ((int'(dg >> (4 * j)) & 15) != 0)) supp = 1'b0;
    end
    lit = en[d] && !(bl[d] && phase == 1) && !supp && slot >= GC &&
          (int'(br) == (1 << BW) - 1 || pwm < int'(br));
    r.an   = lit ? ~(N'(1) << d) : '1;
    r.seg  = lit ? ~hi_pat[val] : 7'h7F;
    r.dp   = lit ? ~dpm[d] : 1'b1;
    r.tick = ((k + 1) % P == 0);
    return r;
  endfunction

  int             m_e;
  logic [4*N-1:0] m_dig;
  logic [N-1:0]   m_dp, m_en, m_bl;
  logic           m_lzs;

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.push_back('{an: '1, seg: 7'h7F, dp: 1'b1, tick: 1'b0});
      m_e   <= 0;
      m_dig <= '0;
      m_dp  <= '0;
      m_en  <= '0;
      m_bl  <= '0;
      m_lzs <= 1'b0;
    end else begin
      exp_q.push_back(model_out(m_e, m_dig, m_dp, m_en, m_bl, m_lzs, brightness));
      if ((m_e + 1) % P == 0) begin
        m_dig <= digits;
        m_dp  <= dp_in;
        m_en  <= digit_en;
        m_bl  <= blink_en;
        m_lzs <= lzs_en;
      end
      m_e <= m_e + 1;
    end
  end

  exp_t e;
  always @(negedge clk) begin
    cyc_no++;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty cyc=%0d: no expected entry queued", cyc_no);
    end else begin
      e = exp_q.pop_front();
      if ({an, seg, dp, frame_tick} !== e) begin
        errors++;
        $display("FAIL scan cyc=%0d: got an=%b seg=%h dp=%b tick=%b, want an=%b seg=%h dp=%b tick=%b",
                 cyc_no, an, seg, dp, frame_tick, e.an, e.seg, e.dp, e.tick);
      end
    end
    checks++;
    if ($countones(~an) > 1) begin
      errors++;
      $display("FAIL anode_onehot cyc=%0d: got an=%b, want at most one low", cyc_no, an);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    digits = 12'h321; dp_in = 3'b010; digit_en = 3'b111; brightness = 2'd3;
    cyc(3);
    rst_n = 1'b1;
    cyc(72);
    cyc(10); digits = 12'h654; cyc(48);
    digits = 12'h007; lzs_en = 1'b1; cyc(48);
    digits = 12'h000; cyc(48);
    digits = 12'h321; lzs_en = 1'b0; brightness = 2'd1; cyc(48);
    brightness = 2'd0; cyc(48);
    brightness = 2'd3; blink_en = 3'b010; cyc(200);
    cyc(5); rst_n = 1'b0; cyc(1); rst_n = 1'b1; cyc(60);
    for (int i = 0; i < 40; i++) begin
      digits   = 12'($urandom);
      dp_in    = 3'($urandom);
      digit_en = 3'($urandom);
      blink_en = 3'($urandom);
      lzs_en   = 1'($urandom);
      for (int j = 0; j < 24; j++) begin
        if ($urandom_range(0, 3) == 0) brightness = 2'($urandom);
        if ($urandom_range(0, 15) == 0) digits = 12'($urandom);
        cyc(1);
      end
    end
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
